// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared single-precision FP constants and packer state type
// Contents:
//   EXP_W, FRAC_W, BIAS, EXP_MAX  single-precision field geometry
//   QNAN                          canonical quiet NaN word
//   packer_state_t                fp_packer FSM states
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } packer_state_t;

endpackage

// File: rtl/fp_packer_if.sv
// rtl/fp_packer_if.sv - result handshake between arithmetic core and fp_packer
// Signals:
//   data_valid_i, sign_i, exp_i, mant_i, infinity_i, nan_i  core -> packer
//   busy_o, data_ready_o, z_o, z_infinity_o, z_nan_o        packer -> core
// Modports: master (arithmetic core side), slave (packer side)
interface fp_packer_if;
  import fpu_pkg::*;

  logic                       data_valid_i;
  logic                       sign_i;
  logic signed [EXP_W+1:0]    exp_i;
  logic [FRAC_W+4:0]          mant_i;
  logic                       infinity_i;
  logic                       nan_i;
  logic                       busy_o;
  logic                       data_ready_o;
  logic [EXP_W+FRAC_W:0]      z_o;
  logic                       z_infinity_o;
  logic                       z_nan_o;

  modport master (
    output data_valid_i, sign_i, exp_i, mant_i, infinity_i, nan_i,
    input  busy_o, data_ready_o, z_o, z_infinity_o, z_nan_o
  );

  modport slave (
    input  data_valid_i, sign_i, exp_i, mant_i, infinity_i, nan_i,
    output busy_o, data_ready_o, z_o, z_infinity_o, z_nan_o
  );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even decision and significand increment
// Ports:
//   mant   in   FRAC_W+4  [FRAC_W+3]=hidden, [FRAC_W+2:3]=frac, [2]=G [1]=R [0]=S
//   frac   out  FRAC_W    rounded fraction (already renormalized on carry-out)
//   carry  out  1         increment overflowed the hidden bit; exponent must step by one
module fp_round_rne
  import fpu_pkg::*;
(
  input  logic [FRAC_W+3:0] mant,
  output logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic              round_up;
  logic [FRAC_W+1:0] sum;

  // Round up above the halfway point, or exactly at it when the kept LSB is odd.
  assign round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
  assign sum      = {1'b0, mant[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, round_up};
  assign carry    = sum[FRAC_W+1];
  // On carry-out the significand is 10...0, so dropping one bit keeps it exact.
  assign frac     = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];

endmodule

// File: rtl/fp_packer.sv
// rtl/fp_packer.sv - normalize, round (RNE) and pack an FP result into IEEE-754 single
// Ports:
//   clk_i  in  clock, rising edge
//   rst_i  in  asynchronous active-high reset
//   bus    fp_packer_if.slave: operands/flags in, busy/ready/result out
module fp_packer
  import fpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  fp_packer_if.slave bus
);

  localparam int EW = EXP_W + 2;
  localparam int MW = FRAC_W + 5;
  localparam int ZW = 1 + EXP_W + FRAC_W;

  localparam logic signed [EW-1:0] EXP_TOP   = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] EXP_FLOOR = EW'(-(2 ** EXP_W));
  localparam logic signed [EW-1:0] EXP_ZERO  = '0;
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);

  packer_state_t state, next_state;

  logic                 sign_q, inf_q, nan_q;
  logic signed [EW-1:0] exp_q;
  logic [MW-1:0]        mant_q;

  logic [ZW-1:0]        res_z;
  logic                 res_inf, res_nan;
  logic [ZW-1:0]        z_q;
  logic                 z_inf_q, z_nan_q, ready_q;

  logic                 load, shr, shl, fin_special, fin_round, busy;
  logic [FRAC_W-1:0]    rnd_frac;
  logic                 rnd_carry;
  logic signed [EW-1:0] exp_rnd;
  logic [ZW-1:0]        special_z, round_z;
  logic                 round_inf;

  fp_round_rne u_round (
    .mant  (mant_q[MW-2:0]),
    .frac  (rnd_frac),
    .carry (rnd_carry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load        = 1'b0;
    shr         = 1'b0;
    shl         = 1'b0;
    fin_special = 1'b0;
    fin_round   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.data_valid_i) begin
          load       = 1'b1;
          next_state = NORM;
        end
      end
      NORM: begin
        if (nan_q || inf_q || mant_q == '0) begin
          fin_special = 1'b1;
          next_state  = DONE;
        end else if (mant_q[MW-1]) begin
          shr = 1'b1;
        end else if (!mant_q[MW-2] && exp_q > EXP_FLOOR) begin
          // Below the floor the result flushes anyway; stop so exp cannot wrap.
          shl = 1'b1;
        end else begin
          next_state = ROUND;
        end
      end
      ROUND: begin
        fin_round  = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    special_z = '0;
    if (nan_q)      special_z = QNAN;
    else if (inf_q) special_z = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

    exp_rnd   = exp_q + EW'(rnd_carry);
    round_inf = 1'b0;
    round_z   = {sign_q, exp_rnd[EXP_W-1:0], rnd_frac};
    if (exp_rnd >= EXP_TOP) begin
      round_inf = 1'b1;
      round_z   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (exp_rnd <= EXP_ZERO) begin
      round_z   = {sign_q, {(ZW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_q  <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      res_z   <= '0;
      res_inf <= 1'b0;
      res_nan <= 1'b0;
      z_q     <= '0;
      z_inf_q <= 1'b0;
      z_nan_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (load) begin
        sign_q <= bus.sign_i;
        inf_q  <= bus.infinity_i;
        nan_q  <= bus.nan_i;
        exp_q  <= bus.exp_i;
        mant_q <= bus.mant_i;
      end
      if (shr) begin
        // Fold the bit shifted out into sticky so rounding stays exact.
        mant_q <= {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
        exp_q  <= exp_q + EXP_ONE;
      end
      if (shl) begin
        mant_q <= mant_q << 1;
        exp_q  <= exp_q - EXP_ONE;
      end
      if (fin_special) begin
        res_z   <= special_z;
        res_inf <= inf_q & ~nan_q;
        res_nan <= nan_q;
      end
      if (fin_round) begin
        res_z   <= round_z;
        res_inf <= round_inf;
        res_nan <= 1'b0;
      end
      ready_q <= (state == DONE);
      if (state == DONE) begin
        z_q     <= res_z;
        z_inf_q <= res_inf;
        z_nan_q <= res_nan;
      end
    end
  end

  assign bus.busy_o       = busy;
  assign bus.data_ready_o = ready_q;
  assign bus.z_o          = z_q;
  assign bus.z_infinity_o = z_inf_q;
  assign bus.z_nan_o      = z_nan_q;

endmodule

// File: tb/tb_fp_packer.sv
// tb/tb_fp_packer.sv - self-checking bench for fp_packer
module tb_fp_packer;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_packer_if bus();
  fp_packer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        nan;
    logic        inf;
    logic        sign;
    int          exp;
    logic [27:0] mant;
    logic [31:0] z;
    logic        zi;
    logic        zn;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic nan, input logic inf, input logic sign, input int exp,
                       input logic [27:0] mant);
    bus.nan_i      = nan;
    bus.infinity_i = inf;
    bus.sign_i     = sign;
    bus.exp_i      = 10'(exp);
    bus.mant_i     = mant;
  endtask

  // Exact-value reference: locate the leading one, keep 24 significant bits,
  // round the discarded remainder to nearest-even, then range-check the exponent.
  function automatic void ref_model(input logic nan, input logic inf, input logic sign,
                                    input int exp, input logic [27:0] mant,
                                    output logic [31:0] z, output logic zi, output logic zn,
                                    output int lat);
    int p, k, e, room;
    longint m, kept, rem, half;
    z = 32'h0; zi = 1'b0; zn = 1'b0; lat = 2;
    if (nan) begin z = 32'h7FC00000; zn = 1'b1; return; end
    if (inf) begin z = {sign, 8'hFF, 23'h0}; zi = 1'b1; return; end
    if (mant == 28'h0) return;
    m = longint'(mant);
    p = 0;
    for (int b = 0; b < 28; b++) if (mant[b]) p = b;
    room = exp + 256;
    if (room < 0) room = 0;
    if (p == 27)      lat = 4;
    else if (p == 26) lat = 3;
    else              lat = 3 + (((26 - p) < room) ? (26 - p) : room);
    k = p - 23;
    if (k > 0) begin
      kept = m >> k;
      rem  = m & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    end else begin
      kept = m << (-k);
    end
    e = exp + p - 26;
    if (kept == (64'd1 << 24)) begin kept = kept >> 1; e = e + 1; end
    if (e >= 255)    begin z = {sign, 8'hFF, 23'h0}; zi = 1'b1; end
    else if (e <= 0) z = {sign, 31'h0};
    else             z = {sign, e[7:0], kept[22:0]};
  endfunction

  task automatic run_op(input string tag, input logic nan, input logic inf, input logic sign,
                        input int exp, input logic [27:0] mant, input logic [31:0] ez,
                        input logic ezi, input logic ezn, input int elat);
    int   cyc;
    logic got;
    @(negedge clk);
    drive(nan, inf, sign, exp, mant);
    bus.data_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.data_valid_i = 1'b0;
    check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.data_ready_o) got = 1'b1;
    end
    check({tag, " ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"}, 32'(cyc), 32'(elat));
      check({tag, " z"}, bus.z_o, ez);
      check({tag, " z_inf"}, 32'(bus.z_infinity_o), 32'(ezi));
      check({tag, " z_nan"}, 32'(bus.z_nan_o), 32'(ezn));
      @(posedge clk); #1;
      check({tag, " ready_pulse_end"}, 32'(bus.data_ready_o), 32'd0);
      check({tag, " z_hold"}, bus.z_o, ez);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mz;
    logic        mzi, mzn;
    int          mlat, pulses, rexp, sel;
    logic [31:0] last_z;
    logic [27:0] rmant;
    logic        rnan, rinf, rsign;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 129,  28'h8400000, 32'h41040000, 1'b0, 1'b0, 4};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 130,  28'h1000000, 32'h40000000, 1'b0, 1'b0, 5};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 127,  28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 127,  28'h400000C, 32'h3F800002, 1'b0, 1'b0, 3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 127,  28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 254,  28'h8000000, 32'h7F800000, 1'b1, 1'b0, 4};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1,    28'h2000000, 32'h80000000, 1'b0, 1'b0, 4};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 10,   28'h4000000, 32'h7FC00000, 1'b0, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 10,   28'h4000000, 32'hFF800000, 1'b1, 1'b0, 2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 100,  28'h0000000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 10,   28'h4000000, 32'h7FC00000, 1'b0, 1'b1, 2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, -250, 28'h0000001, 32'h80000000, 1'b0, 1'b0, 9};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 0,    28'h4000000, 32'h00000000, 1'b0, 1'b0, 3};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 255,  28'h4000000, 32'h7F800000, 1'b1, 1'b0, 3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 254,  28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 3};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 254,  28'h7FFFFF8, 32'h7F7FFFFF, 1'b0, 1'b0, 3};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 0,    28'h7FFFFFC, 32'h00800000, 1'b0, 1'b0, 3};

    bus.data_valid_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 28'h0);

    repeat (3) @(posedge clk);
    #1;
    check("reset z", bus.z_o, 32'h0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset ready", 32'(bus.data_ready_o), 32'd0);
    check("reset flags", {30'h0, bus.z_infinity_o, bus.z_nan_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle busy", 32'(bus.busy_o), 32'd0);

    for (int i = 0; i < 17; i++)
      run_op($sformatf("vec%0d", i), vecs[i].nan, vecs[i].inf, vecs[i].sign, vecs[i].exp,
             vecs[i].mant, vecs[i].z, vecs[i].zi, vecs[i].zn, vecs[i].lat);

    // data_valid_i held high with changed operands while busy must not start a second op
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 130, 28'h1000000);
    bus.data_valid_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 127, 28'h4000000);
    pulses = 0; last_z = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.data_ready_o) begin pulses++; last_z = bus.z_o; end
      if (c == 1) bus.data_valid_i = 1'b0;
    end
    check("busy_valid pulses", 32'(pulses), 32'd1);
    check("busy_valid z", last_z, 32'h40000000);

    // reset while shifting in NORM
    run_op("pre_reset", 1'b0, 1'b0, 1'b0, 129, 28'h8400000, 32'h41040000, 1'b0, 1'b0, 4);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 100, 28'h0000001);
    bus.data_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_norm busy", 32'(bus.busy_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst z", bus.z_o, 32'h0);
    check("async_rst busy", 32'(bus.busy_o), 32'd0);
    check("async_rst ready", 32'(bus.data_ready_o), 32'd0);
    check("async_rst flags", {30'h0, bus.z_infinity_o, bus.z_nan_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.data_ready_o) pulses++;
    end
    check("post_rst no_pulse", 32'(pulses), 32'd0);
    run_op("post_rst", 1'b0, 1'b0, 1'b0, 129, 28'h8400000, 32'h41040000, 1'b0, 1'b0, 4);

    // randomized operands against the reference model
    for (int i = 0; i < 200; i++) begin
      sel   = int'($urandom_range(0, 19));
      rnan  = (sel == 0);
      rinf  = (sel == 1);
      rsign = 1'($urandom_range(0, 1));
      rexp  = int'($urandom_range(0, 700)) - 300;
      rmant = 28'($urandom) >> $urandom_range(0, 27);
      if (sel == 2) rmant = 28'h0;
      if (sel == 3) rexp = int'($urandom_range(0, 8)) - 4;
      if (sel == 4) rexp = int'($urandom_range(250, 256));
      if (sel == 5) rmant[2:0] = 3'b100;
      ref_model(rnan, rinf, rsign, rexp, rmant, mz, mzi, mzn, mlat);
      run_op($sformatf("rand%0d", i), rnan, rinf, rsign, rexp, rmant, mz, mzi, mzn, mlat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
